// File: rtl/and_input_debounce.sv
//------------------------------------------------------------------------------
// and_input_debounce : two-channel synchronise-and-debounce front end for the
//                      A/B inputs of a downstream AND gate.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module and_input_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic a_chg,
  output logic b_chg,
  output logic stable
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] synced;
  logic [1:0] val;
  logic [1:0] chg;

  assign raw = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             val_q, val_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        val_q  <= 1'b0;
        chg_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        meta_q <= meta_d;
        sync_q <= sync_d;
        val_q  <= val_d;
        chg_q  <= chg_d;
        cnt_q  <= cnt_d;
      end
    end

    // Any cycle of agreement drops the count, so only an unbroken run of
    // DEB_CYCLES mismatching samples is accepted as a new value.
    always_comb begin
      meta_d = raw[ch];
      sync_d = meta_q;
      val_d  = val_q;
      chg_d  = 1'b0;
      cnt_d  = '0;
      if (sync_q != val_q) begin
        if (cnt_q == CNT_MAX) begin
          val_d = sync_q;
          chg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign synced[ch] = sync_q;
    assign val[ch]    = val_q;
    assign chg[ch]    = chg_q;
  end

  assign A      = val[0];
  assign B      = val[1];
  assign a_chg  = chg[0];
  assign b_chg  = chg[1];
  assign stable = (synced == val);

endmodule

`default_nettype wire

// File: doc/and_input_debounce.md
AND_INPUT_DEBOUNCE -- requirements
Module: and_input_debounce

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4; it is the number of consecutive clk cycles of mismatch required before the filtered output accepts a new value; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port a_raw, input, 1 bit: the unsynchronised, possibly bouncing source for gate input A.
REQ-005 The block SHALL have port b_raw, input, 1 bit: the unsynchronised, possibly bouncing source for gate input B.
REQ-006 The block SHALL have port A, output, 1 bit: the debounced, registered value that drives the downstream AND gate input A.
REQ-007 The block SHALL have port B, output, 1 bit: the debounced, registered value that drives the downstream AND gate input B.
REQ-008 The block SHALL have port a_chg, output, 1 bit: a registered pulse, one cycle wide, asserted in the cycle in which A takes a new value.
REQ-009 The block SHALL have port b_chg, output, 1 bit: a registered pulse, one cycle wide, asserted in the cycle in which B takes a new value.
REQ-010 The block SHALL have port stable, output, 1 bit: a combinational flag that is high when both synchronised inputs equal A and B, i.e. no change is pending.

Function
REQ-011 Each raw input SHALL pass through its own two-flop synchroniser (a_s, b_s) before any comparison; the raw inputs SHALL not be used anywhere else.
REQ-012 Each channel SHALL own an independent counter whose width is ceil(log2(DEB_CYCLES)), minimum 1 bit.
REQ-013 On each edge where a_s != A and cntA < DEB_CYCLES-1, the block SHALL increment cntA and hold A.
REQ-014 On each edge where a_s != A and cntA == DEB_CYCLES-1, the block SHALL set A <= a_s, set cntA <= 0 and set a_chg <= 1.
REQ-015 On each edge where a_s == A, the block SHALL clear cntA; any mismatch shorter than DEB_CYCLES cycles SHALL therefore be discarded with no change on A.
REQ-016 a_chg SHALL be 0 on every edge other than the one covered by REQ-014.
REQ-017 Channel B SHALL follow REQ-013..REQ-016 identically using b_s, cntB, B and b_chg.
REQ-018 The two channels SHALL be fully independent; simultaneous A and B updates, with both chg pulses high in the same cycle, are legal.
REQ-019 Latency: if a_raw changes and is first sampled at edge k and then held steady, A SHALL change at edge k+1+DEB_CYCLES.
REQ-020 With DEB_CYCLES=1, A SHALL update on the first edge that sees the mismatch, giving a total of 2 edges after first sample.
REQ-021 A counter SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-022 stable SHALL equal (a_s == A) && (b_s == B).

Reset
REQ-023 While rst_n = 0, all of the following SHALL be 0 immediately, independent of clk: synchroniser flops, cntA, cntB, A, B, a_chg and b_chg; stable therefore reads 1.
REQ-024 Reset asserted mid-count SHALL discard the pending change.
REQ-025 After rst_n deasserts, filtering SHALL restart from zero counts, with the first sampling on the next rising edge.

Verification (DEB_CYCLES=4)
REQ-026 Scenario: reset, then a_raw=1 held from edge 10 -> A rises at edge 15, a_chg=1 only in the cycle after edge 15, stable=0 from edge 11 to edge 14.
REQ-027 Scenario: with A=0, pulse a_raw=1 for 3 cycles -> A stays 0, a_chg stays 0, and cntA returns to 0.
REQ-028 Scenario: a_raw and b_raw both 0->1 on the same edge -> A and B rise on the same edge, and a_chg and b_chg pulse together.
REQ-029 Scenario: a_raw bounces 1,0,1,1,1,1 (one value per cycle) -> A rises only after 4 consecutive synchronised 1s, so no early change occurs.
REQ-030 Scenario: rst_n pulsed low asynchronously while cntA=2 -> A=0 and cntA=0 immediately; with a_raw still 1, A rises 5 edges after the first post-reset sample.
REQ-031 Scenario: sweep the truth table 00, 01, 10, 11 on (a_raw, b_raw), holding each for 10 cycles -> A and B match each pair with 5-edge lag, the downstream Y equals A & B, and each transition produces exactly one chg pulse.
